// File: rtl/input_tile_feeder.sv
// Input tile feeder: walks a feature map in overlapping 6x6 tiles, reads each tile
// pixel by pixel from memory and hands the finished tile to the first PE.
module input_tile_feeder (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [15:0]       base_addr,
    input  logic [8:0]        total_height,
    input  logic [8:0]        total_width,
    input  logic              weight_size,
    output logic              mem_rd_en,
    output logic [15:0]       mem_rd_addr,
    input  logic signed [7:0] mem_rd_data,
    output logic signed [7:0] input_tile [36],
    output logic              input_valid,
    input  logic              tile_ready,
    output logic [8:0]        low_height_index,
    output logic [8:0]        high_height_index,
    output logic [8:0]        low_width_index,
    output logic [8:0]        high_width_index,
    output logic              busy,
    output logic              done
);
    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, PRESENT, DONE} state_t;
    state_t state_reg, state_next;

    logic [15:0]       base_reg;
    logic [8:0]        height_reg, width_reg;
    logic              ws_reg;
    logic [8:0]        row0_reg, col0_reg;
    logic [5:0]        slot_reg;
    logic [2:0]        srow_reg, scol_reg;
    logic              cap_pend_reg, cap_inb_reg;
    logic [5:0]        cap_idx_reg;
    logic signed [7:0] tile_reg [36];
    logic [8:0]        lo_h_reg, hi_h_reg, lo_w_reg, hi_w_reg;

    // Last pixel index of a tile starting at origin, clipped to the map edge.
    function automatic logic [8:0] hi_index(input logic [8:0] origin, input logic [8:0] dim);
        logic [9:0] far;
        far = {1'b0, origin} + 10'd5;
        if (far < {1'b0, dim})
            return far[8:0];
        return dim - 9'd1;
    endfunction

    logic [9:0] step, kern, start_kern;
    logic       start_has_tile, more_cols, more_rows, last_tile;
    logic [8:0] next_row, next_col;

    assign step       = ws_reg ? 10'd4 : 10'd6;
    assign kern       = ws_reg ? 10'd2 : 10'd0;
    assign start_kern = weight_size ? 10'd2 : 10'd0;
    assign start_has_tile = ({1'b0, total_height} > start_kern) && ({1'b0, total_width} > start_kern);

    // An origin X exists while X < dim - K, i.e. X + K < dim, which avoids negative bounds.
    assign more_cols = ({1'b0, col0_reg} + step + kern) < {1'b0, width_reg};
    assign more_rows = ({1'b0, row0_reg} + step + kern) < {1'b0, height_reg};
    assign last_tile = !more_cols && !more_rows;
    assign next_col  = more_cols ? col0_reg + step[8:0] : 9'd0;
    assign next_row  = more_cols ? row0_reg : row0_reg + step[8:0];

    logic [9:0]  pix_row, pix_col;
    logic [19:0] pix_offset;
    logic        in_bounds;

    assign pix_row    = {1'b0, row0_reg} + {7'd0, srow_reg};
    assign pix_col    = {1'b0, col0_reg} + {7'd0, scol_reg};
    assign in_bounds  = (pix_row < {1'b0, height_reg}) && (pix_col < {1'b0, width_reg});
    assign pix_offset = {10'd0, pix_row} * {11'd0, width_reg} + {10'd0, pix_col};

    assign mem_rd_en   = (state_reg == FETCH) && in_bounds;
    assign mem_rd_addr = mem_rd_en ? 16'({4'd0, base_reg} + pix_offset) : 16'd0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next  = state_reg;
        busy        = 1'b1;
        input_valid = 1'b0;
        done        = 1'b0;
        case (state_reg)
            IDLE: begin
                busy = 1'b0;
                if (start)
                    state_next = start_has_tile ? FETCH : DONE;
            end
            FETCH:   if (slot_reg == 6'd35) state_next = DRAIN;
            DRAIN:   state_next = PRESENT;
            PRESENT: begin
                input_valid = 1'b1;
                if (tile_ready)
                    state_next = last_tile ? DONE : FETCH;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base_reg     <= '0;
            height_reg   <= '0;
            width_reg    <= '0;
            ws_reg       <= 1'b0;
            row0_reg     <= '0;
            col0_reg     <= '0;
            slot_reg     <= '0;
            srow_reg     <= '0;
            scol_reg     <= '0;
            cap_pend_reg <= 1'b0;
            cap_inb_reg  <= 1'b0;
            cap_idx_reg  <= '0;
            lo_h_reg     <= '0;
            hi_h_reg     <= '0;
            lo_w_reg     <= '0;
            hi_w_reg     <= '0;
        end else begin
            cap_pend_reg <= (state_reg == FETCH);
            cap_inb_reg  <= in_bounds;
            cap_idx_reg  <= slot_reg;
            if (state_reg == IDLE && start) begin
                base_reg   <= base_addr;
                height_reg <= total_height;
                width_reg  <= total_width;
                ws_reg     <= weight_size;
                row0_reg   <= '0;
                col0_reg   <= '0;
                slot_reg   <= '0;
                srow_reg   <= '0;
                scol_reg   <= '0;
                lo_h_reg   <= '0;
                lo_w_reg   <= '0;
                hi_h_reg   <= start_has_tile ? hi_index(9'd0, total_height) : 9'd0;
                hi_w_reg   <= start_has_tile ? hi_index(9'd0, total_width) : 9'd0;
            end else if (state_reg == FETCH) begin
                slot_reg <= slot_reg + 6'd1;
                if (scol_reg == 3'd5) begin
                    scol_reg <= '0;
                    srow_reg <= srow_reg + 3'd1;
                end else begin
                    scol_reg <= scol_reg + 3'd1;
                end
            end else if (state_reg == PRESENT && tile_ready && !last_tile) begin
                row0_reg <= next_row;
                col0_reg <= next_col;
                slot_reg <= '0;
                srow_reg <= '0;
                scol_reg <= '0;
                lo_h_reg <= next_row;
                lo_w_reg <= next_col;
                hi_h_reg <= hi_index(next_row, height_reg);
                hi_w_reg <= hi_index(next_col, width_reg);
            end
        end
    end

    // Read data lands one cycle after issue; skipped (out-of-map) slots load zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 36; i++)
                tile_reg[i] <= '0;
        end else if (cap_pend_reg) begin
            tile_reg[cap_idx_reg] <= cap_inb_reg ? mem_rd_data : 8'sd0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 36; gi++) begin : g_tile_out
            assign input_tile[gi] = tile_reg[gi];
        end
    endgenerate

    assign low_height_index  = lo_h_reg;
    assign high_height_index = hi_h_reg;
    assign low_width_index   = lo_w_reg;
    assign high_width_index  = hi_w_reg;
endmodule
